// File: rtl/cover_toggle_collector.sv
// Sticky toggle-coverage bitmap that reports each point's first hit once over a valid/ready stream.
// Optional simulation-only report counter when COVER_TOGGLE_DPI_EN is defined (ignored under SYNTHESIS).
module cover_toggle_collector #(
  parameter int WIDTH       = 42,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 38253
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_index,
  output logic [$clog2(WIDTH+1)-1:0]   covered_count,
  output logic                         all_covered
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
      $fatal(1, "cover_toggle_collector: WIDTH must be 1..1024");
    end
    if (COVER_INDEX < 0 || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
      $fatal(1, "cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end
  endgenerate

  logic [WIDTH-1:0] covered;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] new_hits;
  logic [WIDTH-1:0] sel_hot;
  logic [IW-1:0]    sel_idx;
  logic [CW-1:0]    hit_count;
  logic             free;
  logic             load;

  assign new_hits = valid & ~covered;
  assign free     = ~out_valid | out_ready;
  // No load on a clear edge: the pending bitmap is being discarded.
  assign load     = free & (|pending) & ~clear;
  assign sel_hot  = pending & (~pending + WIDTH'(1));

  always_comb begin
    sel_idx = '0;
    for (int i = WIDTH-1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit_count = hit_count + CW'(new_hits[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      covered       <= '0;
      pending       <= '0;
      covered_count <= '0;
      out_valid     <= 1'b0;
      out_index     <= '0;
    end else begin
      if (clear) begin
        covered       <= '0;
        pending       <= '0;
        covered_count <= '0;
      end else begin
        covered       <= covered | new_hits;
        pending       <= (load ? (pending & ~sel_hot) : pending) | new_hits;
        covered_count <= covered_count + hit_count;
      end
      if (free) begin
        if (load) begin
          out_valid <= 1'b1;
          out_index <= 32'(COVER_INDEX) + 32'(sel_idx);
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign all_covered = (covered_count == CW'(WIDTH));

`ifdef COVER_TOGGLE_DPI_EN
`ifndef SYNTHESIS
  longint mirror_count = 0;

  always @(posedge clock) begin
    if (!reset && out_valid && out_ready) mirror_count <= mirror_count + 1;
  end
`endif
`endif

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector: vector table plus drain, clear and async-reset sequences.
module tb_cover_toggle_collector;

  localparam int W  = 42;
  localparam int CI = 100;
  localparam int CW = $clog2(W+1);

  logic          clock;
  logic          reset;
  logic [W-1:0]  valid;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_index;
  logic [CW-1:0] covered_count;
  logic          all_covered;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] v;
    logic         clr;
    logic         rdy;
    logic         ev;
    int           ei;
    int           ec;
    logic         ea;
  } vec_t;

  vec_t vecs[$];

  cover_toggle_collector #(
    .WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(38253)
  ) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .covered_count(covered_count), .all_covered(all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] b(input int n);
    logic [W-1:0] one;
    one = W'(1);
    return one << n;
  endfunction

  function automatic void add(input logic [W-1:0] v, input logic clr, input logic rdy,
                              input logic ev, input int ei, input int ec, input logic ea);
    vec_t t;
    t.v = v; t.clr = clr; t.rdy = rdy; t.ev = ev; t.ei = ei; t.ec = ec; t.ea = ea;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [W-1:0] v, input logic c, input logic r);
    valid = v; clear = c; out_ready = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; valid = '0; clear = 1'b0; out_ready = 1'b1;

    // single pulse on bit 5: report two edges later, once
    add(b(5), 0, 1, 0, 0,   1, 0);
    add('0,   0, 1, 1, 105, 1, 0);
    add('0,   0, 1, 0, 0,   1, 0);
    for (int k = 0; k < 3; k++) begin
      add(b(5), 0, 1, 0, 0, 1, 0);
      add('0,   0, 1, 0, 0, 1, 0);
    end
    // back-pressure: 103 held, then 103 and 107 back to back
    add(b(3) | b(7), 0, 0, 0, 0, 3, 0);
    for (int k = 0; k < 10; k++) add('0, 0, 0, 1, 103, 3, 0);
    add('0, 0, 1, 1, 107, 3, 0);
    add('0, 0, 1, 0, 0,   3, 0);
    // clear drops pending but delivers the held report
    add('0,        1, 1, 0, 0,   0,  0);
    add(W'('h1FF8), 0, 0, 0, 0,   10, 0);
    add('0,        0, 0, 1, 103, 10, 0);
    add(b(20),     1, 0, 1, 103, 0,  0);
    add('0,        0, 1, 0, 0,   0,  0);
    add('0,        0, 1, 0, 0,   0,  0);
    add(b(3),      0, 1, 0, 0,   1,  0);
    add('0,        0, 1, 1, 103, 1,  0);
    add('0,        0, 1, 0, 0,   1,  0);

    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_index", out_index, 0);
    chk("rst_count", covered_count, 0);
    chk("rst_all",   all_covered, 0);
    #9 reset = 1'b0;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].clr, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("vec%0d_index", i), out_index, vecs[i].ei);
      chk($sformatf("vec%0d_count", i), covered_count, vecs[i].ec);
      chk($sformatf("vec%0d_all", i), all_covered, vecs[i].ea);
    end

    // all points at once: 42 consecutive ascending reports
    step('0, 1, 1);
    step('1, 0, 1);
    chk("drain_count", covered_count, 42);
    chk("drain_all", all_covered, 1);
    chk("drain_pre_valid", out_valid, 0);
    for (int k = 0; k < W; k++) begin
      step('0, 0, 1);
      chk($sformatf("drain%0d_valid", k), out_valid, 1);
      chk($sformatf("drain%0d_index", k), out_index, CI + k);
    end
    step('0, 0, 1);
    chk("drain_end_valid", out_valid, 0);
    chk("drain_end_all", all_covered, 1);

    // pending and a new hit at the same edge: older pending bit goes first
    step('0, 1, 1);
    step(b(30), 0, 0);
    step(b(2), 0, 1);
    chk("order_first", out_index, CI + 30);
    step('0, 0, 1);
    chk("order_second_valid", out_valid, 1);
    chk("order_second", out_index, CI + 2);
    step('0, 0, 1);
    chk("order_done", out_valid, 0);

    // asynchronous reset between edges while a report is held
    step('0, 1, 1);
    step(b(9), 0, 0);
    step('0, 0, 0);
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_index", out_index, CI + 9);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_index", out_index, 0);
    chk("async_rst_count", covered_count, 0);
    @(posedge clock); #2 reset = 1'b0;
    step('0, 0, 1);
    step('0, 0, 1);
    chk("post_reset_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
